// File: rtl/lcd_host_seq.sv
// lcd_host_seq
// Command sequencer in front of the LCD controller. Host requests are queued,
// issued one at a time whenever the controller is idle, and a load command
// streams the image memory onto datain at one byte per cycle. Output frames
// coming back from the controller are counted and checked for length.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   req_cmd      host command (0 load, 1 zoom in, 2 fit, 3 R, 4 L, 5 U, 6 D)
//   req_valid    host request strobe
//   req_ready    queue can take a request this cycle
//   img_addr     image memory read address
//   img_rd       image memory read enable
//   img_data     image memory read data (captured into datain)
//   cmd          command to the LCD controller
//   cmd_valid    command strobe, one cycle per request
//   datain       image byte to the LCD controller
//   busy         controller busy
//   lcd_valid    controller output_valid
//   frames_done  completed output frames, wrapping
//   frame_err    sticky: some frame had the wrong byte count
//   seq_idle     nothing queued and nothing in flight
//
// FSM states
//   state     | meaning
//   IDLE      | nothing to issue
//   ARMED     | head of queue presented on cmd, waiting for busy low to issue
//   LOAD      | streaming image bytes 1..IMG_BYTES-1 (byte 0 read in issue cycle)
//   WAIT_DONE | command issued, waiting for the controller to finish it
module lcd_host_seq #(
    parameter int FIFO_DEPTH  = 4,
    parameter int IMG_BYTES   = 108,
    parameter int FRAME_BYTES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_cmd,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [6:0]  img_addr,
    output logic        img_rd,
    input  logic [7:0]  img_data,
    output logic [2:0]  cmd,
    output logic        cmd_valid,
    output logic [7:0]  datain,
    input  logic        busy,
    input  logic        lcd_valid,
    output logic [15:0] frames_done,
    output logic        frame_err,
    output logic        seq_idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ARMED     = 2'd1;
    localparam logic [1:0] S_LOAD      = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       fifo_q [FIFO_DEPTH];
    logic [2:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [6:0]       load_addr_q, load_addr_d;
    logic             armed_seen_q, armed_seen_d;
    logic [7:0]       datain_q, datain_d;
    logic             lcd_valid_q, lcd_valid_d;
    logic [4:0]       byte_cnt_q, byte_cnt_d;
    logic [15:0]      frames_done_q, frames_done_d;
    logic             frame_err_q, frame_err_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic [2:0]       head;
    logic             issue;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];

    // The controller may drop busy for a single cycle only, so the issue
    // decision has to be combinational on busy.
    assign issue      = (state_q == S_ARMED) && !busy && !fifo_empty;
    assign pop        = issue;
    assign req_ready  = !fifo_full || pop;
    assign push       = req_valid && req_ready;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q[PTR_W-1:0]] = req_cmd;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        load_addr_d  = load_addr_q;
        armed_seen_d = armed_seen_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (issue) begin
                    armed_seen_d = 1'b0;
                    if (head == 3'd0) begin
                        // Byte 0 is read in the issue cycle itself.
                        state_d     = S_LOAD;
                        load_addr_d = 7'd1;
                    end else begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (busy) begin
                    armed_seen_d = 1'b1;
                end
                if (load_addr_q == 7'(IMG_BYTES - 1)) begin
                    state_d     = S_WAIT_DONE;
                    load_addr_d = 7'd0;
                end else begin
                    load_addr_d = load_addr_q + 7'd1;
                end
            end
            S_WAIT_DONE: begin
                if (busy) begin
                    armed_seen_d = 1'b1;
                end
                // Once the controller has taken the command, move to ARMED
                // early when more work is queued so the issue lands in the
                // very cycle busy goes low.
                if (armed_seen_q) begin
                    if (!fifo_empty) begin
                        state_d = S_ARMED;
                    end else if (!busy) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_valid = issue;
    assign cmd       = (state_q == S_ARMED) ? head : 3'd0;
    assign img_rd    = (issue && (head == 3'd0)) || (state_q == S_LOAD);
    assign img_addr  = (state_q == S_LOAD) ? load_addr_q : 7'd0;
    assign seq_idle  = (state_q == S_IDLE) && fifo_empty;

    // img_data follows img_addr within the cycle; datain presents it next cycle
    // and holds the last byte after the stream ends.
    always_comb begin
        datain_d = datain_q;
        if (img_rd) begin
            datain_d = img_data;
        end
    end

    assign datain = datain_q;

    // ------------------------------------------------------------------
    // Frame monitor
    // ------------------------------------------------------------------
    always_comb begin
        lcd_valid_d   = lcd_valid;
        byte_cnt_d    = byte_cnt_q;
        frames_done_d = frames_done_q;
        frame_err_d   = frame_err_q;
        if (lcd_valid) begin
            // Saturate so a very long frame cannot wrap back to a legal count.
            if (byte_cnt_q != 5'h1f) begin
                byte_cnt_d = byte_cnt_q + 5'd1;
            end
        end else if (lcd_valid_q) begin
            frames_done_d = frames_done_q + 16'd1;
            byte_cnt_d    = 5'd0;
            if (byte_cnt_q != 5'(FRAME_BYTES)) begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign frames_done = frames_done_q;
    assign frame_err   = frame_err_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 3'd0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            load_addr_q   <= 7'd0;
            armed_seen_q  <= 1'b0;
            datain_q      <= 8'd0;
            lcd_valid_q   <= 1'b0;
            byte_cnt_q    <= 5'd0;
            frames_done_q <= 16'd0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            load_addr_q   <= load_addr_d;
            armed_seen_q  <= armed_seen_d;
            datain_q      <= datain_d;
            lcd_valid_q   <= lcd_valid_d;
            byte_cnt_q    <= byte_cnt_d;
            frames_done_q <= frames_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_lcd_host_seq.sv
// tb_lcd_host_seq
// Directed bench for lcd_host_seq. Stimulus pushes the expected command into a
// scoreboard queue; a negedge monitor pops and compares on every cmd_valid and
// follows each load stream byte by byte. A small behavioural LCD controller
// answers each command with busy and a frame of lcd_valid bytes.
module tb_lcd_host_seq;

    localparam int IMG_BYTES = 108;

    logic        clk;
    logic        reset;
    logic [2:0]  req_cmd;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  img_addr;
    logic        img_rd;
    logic [7:0]  img_data;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic [7:0]  datain;
    logic        busy;
    logic        lcd_valid;
    logic [15:0] frames_done;
    logic        frame_err;
    logic        seq_idle;

    lcd_host_seq dut (
        .clk         (clk),
        .reset       (reset),
        .req_cmd     (req_cmd),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .img_addr    (img_addr),
        .img_rd      (img_rd),
        .img_data    (img_data),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .datain      (datain),
        .busy        (busy),
        .lcd_valid   (lcd_valid),
        .frames_done (frames_done),
        .frame_err   (frame_err),
        .seq_idle    (seq_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Image memory: asynchronous read.
    logic [7:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'((i * 37 + 11) ^ 8'h5a);
        end
    end
    assign img_data = mem[img_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // LCD controller model
    // ------------------------------------------------------------------
    logic        m_busy = 1'b0;
    logic        hold_busy = 1'b0;
    logic        m_lcd = 1'b0;
    int          m_phase = 0;
    int          m_cnt = 0;
    int          frame_len = 16;
    logic [15:0] exp_frames = 16'd0;
    logic        exp_err = 1'b0;

    assign busy      = m_busy | hold_busy;
    assign lcd_valid = m_lcd;

    initial begin
        logic       acc;
        logic [2:0] acc_cmd;
        forever begin
            @(negedge clk);
            acc     = cmd_valid && !reset;
            acc_cmd = cmd;
            @(posedge clk);
            #1;
            if (reset) begin
                m_phase = 0;
                m_busy  = 1'b0;
                m_lcd   = 1'b0;
            end else begin
                case (m_phase)
                    0: if (acc) begin
                        m_busy  = 1'b1;
                        m_phase = 1;
                        m_cnt   = (acc_cmd == 3'd0) ? IMG_BYTES + 4 : 5;
                    end
                    1: if (m_cnt == 0) begin
                        m_phase = 2;
                        m_lcd   = 1'b1;
                        m_cnt   = frame_len - 1;
                    end else begin
                        m_cnt--;
                    end
                    2: if (m_cnt > 0) begin
                        m_cnt--;
                    end else begin
                        m_lcd      = 1'b0;
                        m_phase    = 3;
                        exp_frames = exp_frames + 16'd1;
                        if (frame_len != 16) exp_err = 1'b1;
                    end
                    default: begin
                        m_busy  = 1'b0;
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    logic [2:0] exp_q [$];
    int         issue_count = 0;
    int         low_run = 0;
    bit         chk_low = 1'b0;
    bit         ld_active = 1'b0;
    int         ld_k = 0;

    always @(negedge clk) begin
        if (reset) begin
            ld_active = 1'b0;
            low_run   = 0;
        end else begin
            if (!busy) low_run++;
            else       low_run = 0;
            if (cmd_valid) begin
                logic [2:0] e;
                issue_count++;
                chk("issue_expected", 32'(exp_q.size() > 0), 32'd1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
                chk("issue_cmd", 32'(cmd), 32'(e));
                chk("issue_not_busy", 32'(busy), 32'd0);
                if (chk_low) chk("issue_in_first_low_cycle", 32'(low_run), 32'd1);
                if (cmd == 3'd0) begin
                    ld_active = 1'b1;
                    ld_k      = 0;
                end
            end
            if (ld_active) begin
                if (ld_k < IMG_BYTES) begin
                    chk("load_rd", 32'(img_rd), 32'd1);
                    chk("load_addr", 32'(img_addr), 32'(ld_k));
                end else begin
                    chk("load_rd_end", 32'(img_rd), 32'd0);
                end
                if (ld_k >= 1) begin
                    chk("load_datain", 32'(datain), 32'(mem[7'(ld_k <= IMG_BYTES ? ld_k - 1 : IMG_BYTES - 1)]));
                end
                ld_k++;
                if (ld_k > IMG_BYTES + 1) ld_active = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic push(input logic [2:0] c, input logic exp_ready);
        req_cmd   = c;
        req_valid = 1'b1;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (exp_ready) exp_q.push_back(c);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (seq_idle && m_phase == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", 32'(ok), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_datain", 32'(datain), 32'd0);
        chk("rst_img_addr", 32'(img_addr), 32'd0);
        chk("rst_img_rd", 32'(img_rd), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_seq_idle", 32'(seq_idle), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        int n0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 3'd0;
        #2;
        chk_reset_values();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Load command with the controller idle: full image stream.
        push(3'd0, 1'b1);
        wait_idle(400);
        chk("frames_after_load", 32'(frames_done), 32'(exp_frames));
        chk("err_after_load", 32'(frame_err), 32'd0);

        // Fill the queue while busy is held, then release; each following
        // command must go out in the single cycle busy drops.
        hold_busy = 1'b1;
        chk_low   = 1'b1;
        push(3'd2, 1'b1);
        push(3'd1, 1'b1);
        push(3'd3, 1'b1);
        push(3'd4, 1'b1);
        push(3'd5, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_issue_while_busy", 32'(issue_count), 32'd1);
        @(posedge clk);
        #1;
        hold_busy = 1'b0;
        wait_idle(400);
        chk_low = 1'b0;
        chk("issues_after_batch", 32'(issue_count), 32'd5);

        // Three well-formed frames.
        push(3'd5, 1'b1);
        push(3'd6, 1'b1);
        push(3'd1, 1'b1);
        wait_idle(400);
        chk("frames_x3", 32'(frames_done), 32'd8);
        chk("frames_model", 32'(frames_done), 32'(exp_frames));
        chk("err_clean", 32'(frame_err), 32'd0);

        // Short frame sets the sticky error; a good frame does not clear it.
        frame_len = 15;
        push(3'd2, 1'b1);
        wait_idle(400);
        chk("err_short", 32'(frame_err), 32'(exp_err));
        chk("err_short_set", 32'(frame_err), 32'd1);
        frame_len = 16;
        push(3'd3, 1'b1);
        wait_idle(400);
        chk("err_sticky", 32'(frame_err), 32'd1);
        chk("frames_10", 32'(frames_done), 32'd10);

        // Reset in the middle of a load stream.
        push(3'd0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (img_rd && img_addr == 7'd50) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_byte_50", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_values();
        exp_q.delete();
        exp_frames = 16'd0;
        exp_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n0 = issue_count;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", 32'(seq_idle), 32'd1);
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        chk("post_reset_no_issue", 32'(issue_count), 32'(n0));
        @(posedge clk);
        #1;

        // One more command, then an empty queue must stay quiet.
        push(3'd4, 1'b1);
        wait_idle(400);
        chk("frames_after_reset", 32'(frames_done), 32'(exp_frames));
        n0 = issue_count;
        repeat (40) @(negedge clk);
        chk("quiet_no_issue", 32'(issue_count), 32'(n0));
        chk("quiet_seq_idle", 32'(seq_idle), 32'd1);
        chk("quiet_err", 32'(frame_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
